// File: rtl/mmu_acl_loader_if.sv
// rtl/mmu_acl_loader_if.sv - command and Wishbone master signal bundle for mmu_acl_loader
interface mmu_acl_loader_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [11:0] cmd_start_seg_i;
    logic [12:0] cmd_count_i;
    logic [7:0]  cmd_asid_i;
    logic [7:0]  cmd_flags_i;
    logic        cmd_abort_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic        aborted_o;
    logic [23:0] m_wb_addr_o;
    logic [7:0]  m_wb_data_o;
    logic [7:0]  m_wb_data_i;
    logic        m_wb_strobe_o;
    logic        m_wb_write_o;
    logic        m_wb_stall_i;
    logic        m_wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_start_seg_i, cmd_count_i, cmd_asid_i, cmd_flags_i, cmd_abort_i,
        input  m_wb_data_i, m_wb_stall_i, m_wb_ack_i,
        output cmd_ready_o, busy_o, done_o, error_o, aborted_o,
        output m_wb_addr_o, m_wb_data_o, m_wb_strobe_o, m_wb_write_o
    );

    modport slave (
        output cmd_valid_i, cmd_start_seg_i, cmd_count_i, cmd_asid_i, cmd_flags_i, cmd_abort_i,
        output m_wb_data_i, m_wb_stall_i, m_wb_ack_i,
        input  cmd_ready_o, busy_o, done_o, error_o, aborted_o,
        input  m_wb_addr_o, m_wb_data_o, m_wb_strobe_o, m_wb_write_o
    );
endinterface

// File: rtl/mmu_acl_loader.sv
// rtl/mmu_acl_loader.sv - Wishbone sequencer bulk-writing MMU segment ACL entries
// MMU_ACL_VERIFY_EN adds read-back of ASID/flags per segment with mismatch abort.
module mmu_acl_loader #(
    parameter logic [23:0] MMU_BASE    = 24'hFFFF00,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input logic              wb_clk_i,
    input logic              wb_reset_i,
    mmu_acl_loader_if.master bus
);
`ifdef MMU_ACL_VERIFY_EN
    localparam logic [2:0] LAST_STEP = 3'd5;
`else
    localparam logic [2:0] LAST_STEP = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, DONE} state_t;
    state_t state, state_next;

    logic [11:0] seg;
    logic [12:0] remaining;
    logic [7:0]  asid, flags, cnt, data;
    logic [2:0]  step;
    logic [3:0]  off;
    logic        abort_q, error_q, aborted_q;
    logic        accept, advance, set_err, set_abt, abort_pend, timeout, mismatch;
    logic [12:0] count_clamped;

    assign count_clamped = (bus.cmd_count_i > 13'd4096) ? 13'd4096 : bus.cmd_count_i;
    assign abort_pend    = abort_q | bus.cmd_abort_i;
    assign timeout       = ({24'd0, cnt} + 32'd1) == 32'(ACK_TIMEOUT);

`ifdef MMU_ACL_VERIFY_EN
    assign mismatch = ((step == 3'd4) && (bus.m_wb_data_i != asid)) ||
                      ((step == 3'd5) && (bus.m_wb_data_i != flags));
`else
    logic unused_rd;
    assign unused_rd = ^bus.m_wb_data_i;
    assign mismatch  = 1'b0;
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        set_err    = 1'b0;
        set_abt    = 1'b0;
        case (state)
            IDLE: if (bus.cmd_valid_i) begin
                accept     = 1'b1;
                state_next = (count_clamped == 13'd0) ? DONE : REQ;
            end
            REQ: if (!bus.m_wb_stall_i) begin
                state_next = WAIT_ACK;
            end else if (abort_pend || timeout) begin
                state_next = DONE;
                set_err    = timeout;
                set_abt    = abort_pend;
            end
            WAIT_ACK: if (bus.m_wb_ack_i) begin
                if (mismatch) begin
                    state_next = DONE;
                    set_err    = 1'b1;
                    set_abt    = abort_pend;
                end else if (step == LAST_STEP && remaining == 13'd1) begin
                    advance    = 1'b1;
                    state_next = DONE;
                end else if (abort_pend) begin
                    state_next = DONE;
                    set_abt    = 1'b1;
                end else begin
                    advance    = 1'b1;
                    state_next = REQ;
                end
            end else if (timeout) begin
                state_next = DONE;
                set_err    = 1'b1;
                set_abt    = abort_pend;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) state <= IDLE;
        else            state <= state_next;
    end

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            seg       <= 12'd0;
            remaining <= 13'd0;
            asid      <= 8'd0;
            flags     <= 8'd0;
            step      <= 3'd0;
            cnt       <= 8'd0;
            abort_q   <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (accept) begin
                seg       <= bus.cmd_start_seg_i;
                remaining <= count_clamped;
                asid      <= bus.cmd_asid_i;
                flags     <= bus.cmd_flags_i;
                step      <= 3'd0;
                abort_q   <= 1'b0;
                error_q   <= 1'b0;
                aborted_q <= 1'b0;
            end else if (state != IDLE && bus.cmd_abort_i) begin
                abort_q <= 1'b1;
            end
            // Segment index wraps naturally at 12 bits (0xFFF -> 0x000).
            if (advance) begin
                if (step == LAST_STEP) begin
                    step      <= 3'd0;
                    seg       <= seg + 12'd1;
                    remaining <= remaining - 13'd1;
                end else begin
                    step <= step + 3'd1;
                end
            end
            if (state_next == REQ && state != REQ) cnt <= 8'd0;
            else if (state == REQ || state == WAIT_ACK) cnt <= cnt + 8'd1;
            if (set_err) error_q <= 1'b1;
            if (set_abt) aborted_q <= 1'b1;
        end
    end

    always_comb begin
        off  = 4'd0;
        data = 8'h00;
        case (step)
            3'd0:    begin off = 4'd4; data = seg[7:0];         end
            3'd1:    begin off = 4'd5; data = {4'h0, seg[11:8]}; end
            3'd2:    begin off = 4'd6; data = asid;              end
            3'd3:    begin off = 4'd7; data = flags;             end
            3'd4:    off = 4'd6;
            3'd5:    off = 4'd7;
            default: off = 4'd0;
        endcase
        if (state == IDLE) begin
            off  = 4'd0;
            data = 8'h00;
        end
    end

    assign bus.cmd_ready_o   = (state == IDLE);
    assign bus.busy_o        = (state != IDLE);
    assign bus.done_o        = (state == DONE);
    assign bus.error_o       = error_q;
    assign bus.aborted_o     = aborted_q;
    assign bus.m_wb_addr_o   = {MMU_BASE[23:4], off};
    assign bus.m_wb_data_o   = data;
    assign bus.m_wb_strobe_o = (state == REQ);
`ifdef MMU_ACL_VERIFY_EN
    assign bus.m_wb_write_o  = (state == REQ) && (step < 3'd4);
`else
    assign bus.m_wb_write_o  = (state == REQ);
`endif
endmodule

// File: tb/tb_mmu_acl_loader.sv
// tb/tb_mmu_acl_loader.sv - scoreboard bench for mmu_acl_loader with a zero-wait Wishbone slave
module tb_mmu_acl_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmu_acl_loader_if bus ();
    mmu_acl_loader #(.MMU_BASE(24'hFFFF00), .ACK_TIMEOUT(8)) dut (
        .wb_clk_i  (clk),
        .wb_reset_i(rst),
        .bus       (bus)
    );

    typedef struct packed {logic [23:0] addr; logic [7:0] data; logic we;} xfer_t;
    typedef struct packed {logic err; logic abt;} done_t;
    xfer_t exp_q[$];
    done_t exp_d[$];

    int total = 0, passed = 0, n_xfer = 0, stall_left = 0, cyc = 0, acc_cyc = 0;
    logic pend = 1'b0;
    logic [7:0] pend_rd = 8'h00;
    logic [7:0] mem [16];
    bit no_ack = 1'b0, bad_rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + slave capture on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (bus.m_wb_strobe_o) begin
                chk("strobe_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("addr", bus.m_wb_addr_o, exp_q[0].addr);
                    chk("data", bus.m_wb_data_o, exp_q[0].data);
                    chk("write", bus.m_wb_write_o, exp_q[0].we);
                    if (!bus.m_wb_stall_i) begin
                        if (bus.m_wb_write_o) mem[bus.m_wb_addr_o[3:0]] = bus.m_wb_data_o;
                        pend_rd = (bad_rd && bus.m_wb_addr_o[3:0] == 4'd6) ? 8'h06 : mem[bus.m_wb_addr_o[3:0]];
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
            pend = bus.m_wb_strobe_o && !bus.m_wb_stall_i && !no_ack;
            if (bus.done_o) begin
                chk("done_expected", 32'(exp_d.size() != 0), 1);
                if (exp_d.size() != 0) begin
                    chk("done_error", bus.error_o, exp_d[0].err);
                    chk("done_aborted", bus.aborted_o, exp_d[0].abt);
                    void'(exp_d.pop_front());
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        bus.m_wb_ack_i  = pend;
        bus.m_wb_data_i = pend ? pend_rd : 8'h00;
        if (!rst && bus.m_wb_strobe_o && bus.m_wb_addr_o[3:0] == 4'd6 && stall_left > 0) begin
            bus.m_wb_stall_i = 1'b1;
            stall_left--;
        end else begin
            bus.m_wb_stall_i = 1'b0;
        end
    end

    task automatic push_x(input logic [3:0] off, input logic [7:0] d, input logic we);
        xfer_t x;
        x.addr = {20'hFFFF0, off};
        x.data = d;
        x.we   = we;
        exp_q.push_back(x);
    endtask

    task automatic push_seg(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] a, input logic [7:0] f);
        push_x(4'd4, lo, 1'b1);
        push_x(4'd5, hi, 1'b1);
        push_x(4'd6, a, 1'b1);
        push_x(4'd7, f, 1'b1);
`ifdef MMU_ACL_VERIFY_EN
        push_x(4'd6, 8'h00, 1'b0);
        push_x(4'd7, 8'h00, 1'b0);
`endif
    endtask

    task automatic push_done(input logic e, input logic a);
        done_t d;
        d.err = e;
        d.abt = a;
        exp_d.push_back(d);
    endtask

    task automatic start_cmd(input logic [11:0] s, input logic [12:0] c, input logic [7:0] a, input logic [7:0] f);
        int k;
        k = 0;
        while (!bus.cmd_ready_o && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ready_before_cmd", bus.cmd_ready_o, 1);
        bus.cmd_valid_i     = 1'b1;
        bus.cmd_start_seg_i = s;
        bus.cmd_count_i     = c;
        bus.cmd_asid_i      = a;
        bus.cmd_flags_i     = f;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        do @(negedge clk); while (!bus.done_o && (cyc - acc_cyc) < 400);
        chk("done_seen", bus.done_o, 1);
        n = cyc - acc_cyc + 1;
    endtask

    initial begin
        int n, x0, k;
        bus.cmd_valid_i = 1'b0; bus.cmd_start_seg_i = '0; bus.cmd_count_i = '0;
        bus.cmd_asid_i = '0; bus.cmd_flags_i = '0; bus.cmd_abort_i = 1'b0;
        bus.m_wb_data_i = '0; bus.m_wb_stall_i = 1'b0; bus.m_wb_ack_i = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.cmd_ready_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_error", bus.error_o, 0);
        chk("rst_aborted", bus.aborted_o, 0);
        chk("rst_strobe", bus.m_wb_strobe_o, 0);
        chk("rst_write", bus.m_wb_write_o, 0);
        chk("rst_addr", bus.m_wb_addr_o, 24'hFFFF00);
        chk("rst_data", bus.m_wb_data_o, 0);
        rst = 1'b0;

        // Two segments from 0x010 with a zero-wait slave.
        push_seg(8'h10, 8'h00, 8'h05, 8'h04);
        push_seg(8'h11, 8'h00, 8'h05, 8'h04);
        push_done(1'b0, 1'b0);
        x0 = n_xfer;
        start_cmd(12'h010, 13'd2, 8'h05, 8'h04);
        wait_done(n);
`ifdef MMU_ACL_VERIFY_EN
        chk("t1_latency", n, 25);
        chk("t1_xfers", n_xfer - x0, 12);
`else
        chk("t1_latency", n, 17);
        chk("t1_xfers", n_xfer - x0, 8);
`endif
        chk("t1_queue_empty", exp_q.size(), 0);

        // Segment index wrap 0xFFF -> 0x000.
        push_seg(8'hFF, 8'h0F, 8'h3C, 8'h0B);
        push_seg(8'h00, 8'h00, 8'h3C, 8'h0B);
        push_done(1'b0, 1'b0);
        start_cmd(12'hFFF, 13'd2, 8'h3C, 8'h0B);
        wait_done(n);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Abort while idle is ignored; count=0 finishes without bus activity.
        @(posedge clk); #1 bus.cmd_abort_i = 1'b1;
        @(posedge clk); #1 bus.cmd_abort_i = 1'b0;
        push_done(1'b0, 1'b0);
        x0 = n_xfer;
        start_cmd(12'h100, 13'd0, 8'h01, 8'h02);
        wait_done(n);
        chk("t3_latency", n, 1);
        @(negedge clk);
        chk("t3_ready_after_done", bus.cmd_ready_o, 1);
        chk("t3_no_xfers", n_xfer - x0, 0);

        // Slave never acks: timeout after ACK_TIMEOUT=8.
        no_ack = 1'b1;
        push_x(4'd4, 8'h40, 1'b1);
        push_done(1'b1, 1'b0);
        x0 = n_xfer;
        start_cmd(12'h240, 13'd1, 8'h11, 8'h22);
        wait_done(n);
        chk("t4_done_within_9", 32'(n <= 9), 1);
        chk("t4_one_strobe", n_xfer - x0, 1);
        chk("t4_error", bus.error_o, 1);
        no_ack = 1'b0;

        // Stall step 2 for 3 cycles, then abort during its WAIT_ACK.
        stall_left = 3;
        push_x(4'd4, 8'h23, 1'b1);
        push_x(4'd5, 8'h01, 1'b1);
        push_x(4'd6, 8'h5A, 1'b1);
        push_done(1'b0, 1'b1);
        x0 = n_xfer;
        start_cmd(12'h123, 13'd1, 8'h5A, 8'h0E);
        k = 0;
        do begin @(negedge clk); k++; end
        while (!(bus.m_wb_strobe_o && !bus.m_wb_stall_i && bus.m_wb_addr_o[3:0] == 4'd6) && k < 100);
        chk("t5_step2_accepted", bus.m_wb_addr_o[3:0], 4'd6);
        @(posedge clk); #1 bus.cmd_abort_i = 1'b1;
        @(posedge clk); #1 bus.cmd_abort_i = 1'b0;
        wait_done(n);
        chk("t5_latency", n, 10);
        chk("t5_xfers", n_xfer - x0, 3);
        chk("t5_aborted", bus.aborted_o, 1);
        chk("t5_error_cleared", bus.error_o, 0);
        chk("t5_stall_used", stall_left, 0);

`ifdef MMU_ACL_VERIFY_EN
        // Verify read of off6 returns 0x06 instead of 0x05.
        bad_rd = 1'b1;
        push_x(4'd4, 8'h20, 1'b1);
        push_x(4'd5, 8'h00, 1'b1);
        push_x(4'd6, 8'h05, 1'b1);
        push_x(4'd7, 8'h04, 1'b1);
        push_x(4'd6, 8'h00, 1'b0);
        push_done(1'b1, 1'b0);
        x0 = n_xfer;
        start_cmd(12'h020, 13'd2, 8'h05, 8'h04);
        wait_done(n);
        chk("t6_xfers", n_xfer - x0, 5);
        chk("t6_error", bus.error_o, 1);
        bad_rd = 1'b0;
`endif

        // Reset mid-command drops strobe at once and yields no done.
        push_seg(8'h01, 8'h00, 8'h77, 8'h01);
        start_cmd(12'h001, 13'd1, 8'h77, 8'h01);
        @(negedge clk);
        chk("t7_strobe_before_rst", bus.m_wb_strobe_o, 1);
        rst = 1'b1;
        #1;
        chk("t7_strobe_dropped", bus.m_wb_strobe_o, 0);
        chk("t7_ready_in_rst", bus.cmd_ready_o, 1);
        chk("t7_addr_in_rst", bus.m_wb_addr_o, 24'hFFFF00);
        exp_q.delete();
        exp_d.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t7_idle_after_rst", bus.busy_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
